rca_pipe: RTL and testbench



---
 rtl/rca_pkg.sv | 12 +
 rtl/rca_seg.sv | 33 +++
 rtl/rca_pipe.sv | 132 +++++++++++++
 tb/tb_rca_pipe.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder family.
package rca_pkg;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // Number of pipeline stages, one per SEG-bit segment of the operand.
  function automatic int stage_count(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/rca_seg.sv
// Combinational SEG-bit generate/propagate ripple segment; exposes the carry
// into its top bit so the last stage can derive signed overflow.
module rca_seg #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < SEG; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
  end

  assign s     = p ^ c[SEG-1:0];
  assign co    = c[SEG];
  assign c_msb = c[SEG-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder: one SEG-bit segment per stage, carry registered
// between stages, valid/ready on both sides with a single global advance.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int STAGES = stage_count(WIDTH, SEG);

  if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
    $error("rca_pipe: WIDTH (%0d) must be a nonzero multiple of SEG (%0d)", WIDTH, SEG);
  end

  logic              advance;
  logic              accept;
  logic              ready_en;

  // Rank k holds the operands, mode and carry that stage k consumes; the
  // operand ranks form the input skew, the partial-sum ranks the output deskew.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [WIDTH-1:0]  sum_nx[STAGES];
  logic [STAGES-1:0] sgn_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES:0]   v_q;
  logic              ext_q;
  logic              ovf_q;

  logic [SEG-1:0]    seg_s   [STAGES];
  logic              seg_co  [STAGES];
  logic              seg_cmsb[STAGES];

  logic              p_top;
  logic              c_top;
  logic              ext_nx;
  logic              ovf_nx;

  assign advance  = !v_q[STAGES] || out_ready;
  assign in_ready = advance && ready_en;
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] prev;

    if (k == 0) begin : g_first
      assign prev = '0;
    end else begin : g_chain
      assign prev = sum_q[k-1];
    end

    rca_seg #(.SEG(SEG)) u_seg (
      .a     (a_q[k][k*SEG +: SEG]),
      .b     (b_q[k][k*SEG +: SEG]),
      .ci    (c_q[k]),
      .s     (seg_s[k]),
      .co    (seg_co[k]),
      .c_msb (seg_cmsb[k])
    );

    // Bits above segment k of prev are always zero, so OR-ing in the new segment suffices.
    assign sum_nx[k] = prev | (WIDTH'(seg_s[k]) << (k*SEG));
  end

  // Signed mode extends p and g by their MSB, which makes the extra sum bit p[MSB]^c[WIDTH].
  assign p_top  = a_q[STAGES-1][WIDTH-1] ^ b_q[STAGES-1][WIDTH-1];
  assign c_top  = seg_co[STAGES-1];
  assign ext_nx = (sgn_q[STAGES-1] == MODE_SIGNED) ? (p_top ^ c_top) : c_top;
  assign ovf_nx = (sgn_q[STAGES-1] == MODE_SIGNED) ? (seg_cmsb[STAGES-1] ^ c_top) : c_top;

  // Gates in_ready low for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      sgn_q <= '0;
      c_q   <= '0;
      ext_q <= 1'b0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      a_q[0]   <= a;
      b_q[0]   <= b;
      sgn_q[0] <= sgn;
      c_q[0]   <= ci;
      v_q[0]   <= accept;
      for (int k = 1; k < STAGES; k++) begin
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
        sgn_q[k] <= sgn_q[k-1];
        c_q[k]   <= seg_co[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
        sum_q[k] <= sum_nx[k];
        v_q[k+1] <= v_q[k];
      end
      ext_q <= ext_nx;
      ovf_q <= ovf_nx;
    end
  end

  assign out_valid = v_q[STAGES];
  assign s         = {ext_q, sum_q[STAGES-1]};
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rca_pipe.sv
// Scoreboard bench for rca_pipe: a 16/4 instance for directed, backpressure and
// reset tests, plus (8,8), (8,2) and (32,8) instances for a random sweep.
module tb_rca_pipe;

  typedef struct packed {
    logic [32:0] s;
    logic        ovf;
    logic [31:0] t;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, ci, sgn, out_valid, out_ready, ovf;
  logic [15:0] a, b;
  logic [16:0] s;

  logic        sw_valid, sw_ci, sw_sgn;
  logic [31:0] sw_a, sw_b;
  logic [2:0]  sw_rdy, sw_ov, sw_of;
  logic [8:0]  sw_s0, sw_s1;
  logic [32:0] sw_s2;
  logic [32:0] sw_sx [3];

  exp_t        exp_q[$];
  exp_t        sw_q[3][$];
  exp_t        mon_e, sw_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  bit          lat_check = 1'b1;
  bit          bp_mode = 1'b0;
  int          bp_i = 0;
  bit          held = 1'b0;
  logic [16:0] held_s;
  logic        held_o;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_pipe #(.WIDTH(16), .SEG(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .ovf(ovf)
  );

  rca_pipe #(.WIDTH(8), .SEG(8)) u_sw0 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[0]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .sgn(sw_sgn),
    .out_valid(sw_ov[0]), .out_ready(1'b1), .s(sw_s0), .ovf(sw_of[0])
  );

  rca_pipe #(.WIDTH(8), .SEG(2)) u_sw1 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[1]),
    .a(sw_a[7:0]), .b(sw_b[7:0]), .ci(sw_ci), .sgn(sw_sgn),
    .out_valid(sw_ov[1]), .out_ready(1'b1), .s(sw_s1), .ovf(sw_of[1])
  );

  rca_pipe #(.WIDTH(32), .SEG(8)) u_sw2 (
    .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_rdy[2]),
    .a(sw_a), .b(sw_b), .ci(sw_ci), .sgn(sw_sgn),
    .out_valid(sw_ov[2]), .out_ready(1'b1), .s(sw_s2), .ovf(sw_of[2])
  );

  assign sw_sx[0] = 33'(sw_s0);
  assign sw_sx[1] = 33'(sw_s1);
  assign sw_sx[2] = sw_s2;

  function automatic int sw_width(input int d);
    return (d == 2) ? 32 : 8;
  endfunction

  function automatic int sw_stages(input int d);
    return (d == 0) ? 1 : 4;
  endfunction

  // Reference: true integer sum a+b+ci; bit 33 is overflow, bits 32:0 the (w+1)-bit result.
  function automatic logic [33:0] model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                        input logic mci, input logic msgn);
    longint m, half, ua, ub, sa, sb, t;
    logic   o;
    m    = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua   = longint'(ma) & m;
    ub   = longint'(mb) & m;
    if (!msgn) begin
      t = ua + ub + longint'(mci);
      o = ((t >> w) & 1) != 0;
    end else begin
      sa = (ua >= half) ? ua - (m + 1) : ua;
      sb = (ub >= half) ? ub - (m + 1) : ub;
      t  = sa + sb + longint'(mci);
      o  = (t >= half) || (t < -half);
    end
    t = t & ((longint'(1) << (w + 1)) - 1);
    return {o, t[32:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [32:0] act, input logic [32:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat was accepted.
  task automatic applyStimulus(input logic [15:0] ta, input logic [15:0] tb, input logic tci,
                               input logic tsgn, input logic [32:0] es, input logic eo);
    int  waits = 0;
    bit  acc;
    logic [31:0] t_edge;
    a = ta; b = tb; ci = tci; sgn = tsgn; in_valid = 1'b1;
    forever begin
      #4;
      acc    = in_ready;
      t_edge = cyc + 1;
      @(negedge clk);
      if (acc) begin
        exp_q.push_back('{s: es, ovf: eo, t: t_edge});
        in_valid = 1'b0;
        break;
      end
      waits++;
      if (waits > 100) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
        in_valid = 1'b0;
        break;
      end
    end
  endtask

  task automatic randomBeat();
    logic [15:0] ra, rb;
    logic        rc, rs;
    logic [33:0] m;
    ra = 16'($urandom); rb = 16'($urandom);
    rc = 1'($urandom); rs = 1'($urandom);
    m  = model(16, {16'h0, ra}, {16'h0, rb}, rc, rs);
    applyStimulus(ra, rb, rc, rs, m[32:0], m[33]);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (bp_mode) begin
      out_ready = (bp_i % 4 == 0) || (bp_i % 4 == 3);
      bp_i++;
    end
  end

  // Main monitor: pops on each consumed result, and checks stability during holds.
  always begin
    @(negedge clk);
    #4;
    if (!rst_n) begin
      held = 1'b0;
    end else begin
      if (out_valid && !out_ready) begin
        checkOutput("hold_in_ready", 33'(in_ready), 33'(0));
        if (held) begin
          checkOutput("hold_s", 33'(s), 33'(held_s));
          checkOutput("hold_ovf", 33'(ovf), 33'(held_o));
        end
        held = 1'b1; held_s = s; held_o = ovf;
      end else begin
        held = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_output: got s=0x%0h, expected no output", s);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sum", 33'(s), mon_e.s);
          checkOutput("ovf", 33'(ovf), 33'(mon_e.ovf));
          if (lat_check) checkOutput("latency", 33'(cyc), 33'(mon_e.t + 4));
        end
      end
    end
  end

  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (sw_ov[d]) begin
          if (sw_q[d].size() == 0) begin
            checks++; errors++;
            $display("[TB] FAIL sweep%0d_unexpected: got s=0x%0h, expected no output", d, sw_sx[d]);
          end else begin
            sw_e = sw_q[d].pop_front();
            checkOutput($sformatf("sweep%0d_sum", d), sw_sx[d], sw_e.s);
            checkOutput($sformatf("sweep%0d_ovf", d), 33'(sw_of[d]), 33'(sw_e.ovf));
            checkOutput($sformatf("sweep%0d_latency", d), 33'(cyc), 33'(sw_e.t + sw_stages(d)));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [33:0] m;
    int          n;
    in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sgn = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_ci = 1'b0; sw_sgn = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_out_valid", 33'(out_valid), 33'(0));
    checkOutput("reset_s", 33'(s), 33'(0));
    checkOutput("reset_ovf", 33'(ovf), 33'(0));
    checkOutput("reset_in_ready", 33'(in_ready), 33'(0));
    rst_n = 1'b1;
    #4;
    checkOutput("release_in_ready", 33'(in_ready), 33'(0));
    @(negedge clk);

    $display("[TB] directed beats");
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, 33'h10000, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, 33'h08000, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b1, 33'h08000, 1'b1);
    applyStimulus(16'hFFFE, 16'hFFFD, 1'b1, 1'b1, 33'h1FFFC, 1'b0);
    applyStimulus(16'h8000, 16'h8000, 1'b0, 1'b1, 33'h10000, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 1'b1, 1'b0, 33'h00001, 1'b0);
    repeat (6) randomBeat();
    drain();

    $display("[TB] backpressure stream");
    lat_check = 1'b0;
    bp_i = 0;
    bp_mode = 1'b1;
    repeat (10) randomBeat();
    drain();
    bp_mode = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    lat_check = 1'b1;

    $display("[TB] reset with beats in flight");
    out_ready = 1'b0;
    repeat (4) randomBeat();
    repeat (2) @(negedge clk);
    #1;
    checkOutput("pre_reset_out_valid", 33'(out_valid), 33'(1));
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 33'(out_valid), 33'(0));
    checkOutput("async_reset_s", 33'(s), 33'(0));
    checkOutput("async_reset_ovf", 33'(ovf), 33'(0));
    checkOutput("async_reset_in_ready", 33'(in_ready), 33'(0));
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #4;
    checkOutput("post_release_in_ready", 33'(in_ready), 33'(0));
    @(negedge clk);
    #4;
    checkOutput("first_edge_in_ready", 33'(in_ready), 33'(1));
    repeat (12) @(negedge clk);
    repeat (3) randomBeat();
    drain();

    $display("[TB] parameter sweep");
    for (int i = 0; i < 1000; i++) begin
      sw_valid = ($urandom % 8) != 0;
      sw_a = $urandom; sw_b = $urandom;
      sw_ci = 1'($urandom); sw_sgn = 1'($urandom);
      #4;
      if (sw_valid) begin
        for (int d = 0; d < 3; d++) begin
          checkOutput($sformatf("sweep%0d_in_ready", d), 33'(sw_rdy[d]), 33'(1));
          if (sw_rdy[d]) begin
            m = model(sw_width(d), sw_a, sw_b, sw_ci, sw_sgn);
            sw_q[d].push_back('{s: m[32:0], ovf: m[33], t: cyc + 1});
          end
        end
      end
      @(negedge clk);
    end
    sw_valid = 1'b0;
    n = 0;
    while ((sw_q[0].size() + sw_q[1].size() + sw_q[2].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if ((sw_q[0].size() + sw_q[1].size() + sw_q[2].size()) != 0) begin
      checks++; errors++;
      $display("[TB] FAIL sweep_drain_timeout: results outstanding, expected none");
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
